// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter (WB > multi-cycle/debug) with pending-write scoreboard.
// Debug port present only when RF_ARB_DBG_EN is defined.
module rf_write_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_wa,
    input  logic [DATA_WIDTH-1:0] wb_wd,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [ADDR_WIDTH-1:0] mc_wa,
    input  logic [DATA_WIDTH-1:0] mc_wd,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [ADDR_WIDTH-1:0] dbg_wa,
    input  logic [DATA_WIDTH-1:0] dbg_wd,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] ra0,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic                  haz_stall,
    output logic                  pipe_freeze,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0] wd,
    output logic                  we
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       pend;
    logic [7:0]            starve_cnt;
    logic [8:0]            starve_inc;
    logic                  wb_gnt;
    logic                  mc_gnt;
    logic                  dbg_gnt;
    logic                  mc_wait;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] ra [3];

    assign wb_gnt = !rst && wb_we;

`ifdef RF_ARB_DBG_EN
    logic mc_req;
    logic dbg_req;
    logic mc_last;

    // mc_last=1 hands the next contested slot to dbg; reset favours mc.
    always_comb begin
        mc_req  = !rst && !wb_we && mc_valid;
        dbg_req = !rst && !wb_we && dbg_valid && !pipe_freeze;
        mc_gnt  = mc_req && (!dbg_req || !mc_last);
        dbg_gnt = dbg_req && (!mc_req || mc_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_last <= 1'b0;
        end else if (mc_gnt) begin
            mc_last <= 1'b1;
        end else if (dbg_gnt) begin
            mc_last <= 1'b0;
        end
    end
`else
    logic unused_dbg;

    assign mc_gnt     = !rst && !wb_we && mc_valid;
    assign dbg_gnt    = 1'b0;
    assign unused_dbg = ^{dbg_valid, dbg_wa, dbg_wd};
`endif

    assign mc_ready  = mc_gnt;
    assign dbg_ready = dbg_gnt;
    assign any_gnt   = wb_gnt || mc_gnt || dbg_gnt;

    always_comb begin
        wa = '0;
        wd = '0;
        unique case (1'b1)
            wb_gnt: begin
                wa = wb_wa;
                wd = wb_wd;
            end
            mc_gnt: begin
                wa = mc_wa;
                wd = mc_wd;
            end
`ifdef RF_ARB_DBG_EN
            dbg_gnt: begin
                wa = dbg_wa;
                wd = dbg_wd;
            end
`endif
            default: ;
        endcase
    end

    assign we = any_gnt && (wa != '0);

    assign iss_ready = !pend[iss_rd] || (iss_rd == '0);

    assign ra[0] = ra0;
    assign ra[1] = ra1;
    assign ra[2] = ra2;

    // A write landing this cycle is forwarded by the register file.
    always_comb begin
        haz_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ra[k] != '0 && pend[ra[k]] &&
                !(mc_gnt && mc_wa == ra[k])) begin
                haz_stall = 1'b1;
            end
        end
    end

    // Later assignment makes a same-cycle issue win over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (mc_gnt) begin
                pend[mc_wa] <= 1'b0;
            end
            if (iss_valid && iss_ready && iss_rd != '0) begin
                pend[iss_rd] <= 1'b1;
            end
        end
    end

    assign mc_wait    = mc_valid && !mc_gnt;
    assign starve_inc = {1'b0, starve_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt  <= 8'd0;
            pipe_freeze <= 1'b0;
        end else begin
            pipe_freeze <= mc_wait &&
                           (starve_inc >= 9'(STARVE_LIMIT));
            if (!mc_wait) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a behavioural model.
// Follows RF_ARB_DBG_EN to decide whether the debug port is modelled.
module tb_rf_write_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 8;
`ifdef RF_ARB_DBG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_wa;
    logic [DW-1:0] mc_wd;
    logic          dbg_valid;
    logic          dbg_ready;
    logic [AW-1:0] dbg_wa;
    logic [DW-1:0] dbg_wd;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          haz_stall;
    logic          pipe_freeze;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .mc_valid(mc_valid), .mc_ready(mc_ready),
        .mc_wa(mc_wa), .mc_wd(mc_wd),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(iss_ready),
        .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .haz_stall(haz_stall), .pipe_freeze(pipe_freeze),
        .wa(wa), .wd(wd), .we(we)
    );

    int errs   = 0;
    int checks = 0;

    // Model state: pending set, last mc/dbg winner (-1 none, 0 mc, 1 dbg),
    // cycles mc has waited, registered freeze.
    bit pend_m [1<<AW];
    int last_win;
    int starve;
    bit frz_m;
    bit e_mcg;
    bit e_dg;
    bit e_irdy;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        last_win = -1;
        starve   = 0;
        frz_m    = 1'b0;
    endtask

    // Combinational expectations for the current inputs.
    task automatic settle();
        bit          wbg, mreq, dreq, hz, xwe;
        int          a;
        logic [AW-1:0] xwa;
        logic [DW-1:0] xwd;
        logic [AW-1:0] rav [3];
        #1;
        wbg  = !rst && wb_we;
        mreq = !rst && !wbg && mc_valid;
        dreq = !rst && !wbg && DBG && dbg_valid && !frz_m;
        if (mreq && dreq) begin
            e_mcg = (last_win != 0);
            e_dg  = !e_mcg;
        end else begin
            e_mcg = mreq;
            e_dg  = dreq;
        end
        xwa = '0;
        xwd = '0;
        if (wbg) begin
            xwa = wb_wa; xwd = wb_wd;
        end else if (e_mcg) begin
            xwa = mc_wa; xwd = mc_wd;
        end else if (e_dg) begin
            xwa = dbg_wa; xwd = dbg_wd;
        end
        xwe = (wbg || e_mcg || e_dg) && xwa != 0;
        e_irdy = (iss_rd == 0) || !pend_m[iss_rd];
        rav = '{ra0, ra1, ra2};
        hz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = int'(rav[k]);
            if (a != 0 && pend_m[a] &&
                !(e_mcg && int'(mc_wa) == a)) hz = 1'b1;
        end
        check("we", we, xwe);
        check("wa", wa, xwa);
        if (xwe || !(wbg || e_mcg || e_dg)) check("wd", wd, xwd);
        check("mc_ready", mc_ready, e_mcg);
        check("dbg_ready", dbg_ready, e_dg);
        check("iss_ready", iss_ready, e_irdy);
        check("haz_stall", haz_stall, hz);
        check("pipe_freeze", pipe_freeze, frz_m);
    endtask

    task automatic adv();
        bit waitm;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_mcg) pend_m[mc_wa] = 1'b0;
            if (iss_valid && e_irdy && iss_rd != 0)
                pend_m[iss_rd] = 1'b1;
            if (e_mcg) last_win = 0;
            if (e_dg) last_win = 1;
            waitm = mc_valid && !e_mcg;
            frz_m = waitm && (starve + 1 >= LIM);
            starve = waitm ? ((starve < 255) ? starve + 1 : 255) : 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_wa = 0; wb_wd = 0;
        mc_valid = 0; mc_wa = 0; mc_wd = 0;
        dbg_valid = 0; dbg_wa = 0; dbg_wd = 0;
        iss_valid = 0; iss_rd = 0;
        ra0 = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        settle();
        adv();
        rst = 0;
    endtask

    initial begin
        model_reset();
        e_mcg = 0; e_dg = 0; e_irdy = 1;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        // Requests during reset are ignored.
        mc_valid = 1; mc_wa = 3; wb_we = 1; wb_wa = 2;
        settle();
        adv();
        idle_inputs();
        do_reset();

        // WB beats mc, mc follows.
        wb_we = 1; wb_wa = 5; wb_wd = 32'hA5A5_0001;
        mc_valid = 1; mc_wa = 6; mc_wd = 32'h0000_0066;
        settle();
        check("wb_first_we", we, 1);
        check("wb_first_wa", wa, 5);
        check("wb_first_mcrdy", mc_ready, 0);
        adv();
        wb_we = 0;
        settle();
        check("mc_next_wa", wa, 6);
        check("mc_next_rdy", mc_ready, 1);
        adv();
        idle_inputs();

`ifdef RF_ARB_DBG_EN
        do_reset();
        mc_valid = 1; mc_wa = 3; dbg_valid = 1; dbg_wa = 4;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_mc", mc_ready, (i % 2) == 0);
            check("rr_dbg", dbg_ready, (i % 2) == 1);
            adv();
        end
        idle_inputs();
        dbg_valid = 1; dbg_wa = 0; dbg_wd = 32'hFFFF_FFFF;
        settle();
        check("x0_rdy", dbg_ready, 1);
        check("x0_we", we, 0);
        adv();
        idle_inputs();
`endif

        // Issue to x7, then hazard, then forwarded clear.
        iss_valid = 1; iss_rd = 7;
        settle();
        check("iss7_rdy", iss_ready, 1);
        adv();
        iss_valid = 0; ra1 = 7;
        settle();
        check("haz7", haz_stall, 1);
        check("iss7_busy", iss_ready, 0);
        adv();
        mc_valid = 1; mc_wa = 7; mc_wd = 32'h7777;
        settle();
        check("haz7_fwd", haz_stall, 0);
        check("mc7_rdy", mc_ready, 1);
        adv();
        mc_valid = 0;
        settle();
        check("haz7_clr", haz_stall, 0);
        check("iss7_free", iss_ready, 1);
        adv();
        idle_inputs();

        // Starvation under continuous WB.
        wb_we = 1; wb_wa = 1; mc_valid = 1; mc_wa = 10;
        for (int i = 0; i < LIM; i++) begin
            settle();
            adv();
        end
        wb_we = 0;
        settle();
        check("freeze_on", pipe_freeze, 1);
        check("freeze_mc", mc_ready, 1);
        adv();
        mc_valid = 0;
        settle();
        check("freeze_off", pipe_freeze, 0);
        adv();

        // Same-cycle issue and mc grant to x9: set wins.
        iss_valid = 1; iss_rd = 9; mc_valid = 1; mc_wa = 9;
        settle();
        adv();
        idle_inputs();
        ra0 = 9; iss_rd = 9;
        settle();
        check("pend9_haz", haz_stall, 1);
        check("pend9_busy", iss_ready, 0);
        adv();
        // Reset mid-stream.
        mc_valid = 1; wb_we = 1; wb_wa = 2;
        do_reset();
        wb_we = 0; mc_valid = 0;
        settle();
        check("rst_haz", haz_stall, 0);
        check("rst_iss", iss_ready, 1);
        check("rst_frz", pipe_freeze, 0);
        adv();

        // Randomized traffic.
        for (int i = 0; i < 1200; i++) begin
            int pct;
            pct = ((i / 150) % 2 == 1) ? 92 : 40;
            rst       = ($urandom_range(99) == 0);
            wb_we     = ($urandom_range(99) < pct);
            wb_wa     = AW'($urandom_range(7));
            wb_wd     = $urandom;
            mc_valid  = ($urandom_range(99) < 60);
            mc_wa     = AW'($urandom_range(7));
            mc_wd     = $urandom;
            dbg_valid = ($urandom_range(99) < 50);
            dbg_wa    = AW'($urandom_range(7));
            dbg_wd    = $urandom;
            iss_valid = ($urandom_range(99) < 30);
            iss_rd    = AW'($urandom_range(7));
            ra0       = AW'($urandom_range(7));
            ra1       = AW'($urandom_range(7));
            ra2       = AW'($urandom_range(7));
            settle();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
